// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multicycle 32-bit ALU with one-bit-per-cycle shifter
module alu_multicycle (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [3:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zero,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [4:0]  count_q;
  logic [31:0] result_q;
  logic        done_q, illegal_q;
  logic        accept, accept_shift;
  logic [31:0] exec_val;
  logic        exec_legal;
  logic [31:0] shift_val;

  assign accept       = start && (state_q == IDLE);
  assign accept_shift = (alu_op == 4'b1000) || (alu_op == 4'b1001) || (alu_op == 4'b1011);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = accept_shift ? SHIFT : EXEC;
      EXEC:    state_d = IDLE;
      SHIFT:   if (count_q == 5'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = done_q;
    result  = result_q;
    illegal = illegal_q;
    zero    = (result_q == 32'd0);
  end

  // Undefined codes also take the EXEC path so they complete with latency 1.
  always_comb begin
    exec_val   = 32'd0;
    exec_legal = 1'b1;
    case (op_q)
      4'b0000: exec_val = a_q + b_q;
      4'b0001: exec_val = a_q - b_q;
      4'b0010: exec_val = {31'd0, $signed(a_q) < $signed(b_q)};
      4'b0011: exec_val = {31'd0, a_q < b_q};
      4'b0100: exec_val = a_q & b_q;
      4'b0101: exec_val = a_q | b_q;
      4'b0110: exec_val = a_q ^ b_q;
      default: exec_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (op_q)
      4'b1000: shift_val = {a_q[30:0], 1'b0};
      4'b1011: shift_val = {a_q[31], a_q[31:1]};
      default: shift_val = {1'b0, a_q[31:1]};
    endcase
  end

  // a_q doubles as the shift working register while in SHIFT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q      <= 4'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      count_q   <= 5'd0;
      result_q  <= 32'd0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          op_q      <= alu_op;
          a_q       <= a;
          b_q       <= b;
          count_q   <= b[4:0];
          illegal_q <= 1'b0;
        end
        EXEC: begin
          result_q  <= exec_val;
          illegal_q <= ~exec_legal;
          done_q    <= 1'b1;
        end
        SHIFT: begin
          if (count_q != 5'd0) begin
            a_q     <= shift_val;
            count_q <= count_q - 5'd1;
          end else begin
            result_q <= a_q;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, zero, illegal;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  alu_multicycle dut (
    .clk(clk), .rstn(rstn), .start(start), .alu_op(alu_op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      4'b0000: return x + y;
      4'b0001: return x - y;
      4'b0010: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b0011: return (x < y) ? 32'd1 : 32'd0;
      4'b0100: return x & y;
      4'b0101: return x | y;
      4'b0110: return x ^ y;
      4'b1000: return x << y[4:0];
      4'b1001: return x >> y[4:0];
      4'b1011: return $signed(x) >>> y[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_undef(input logic [3:0] op);
    return (op == 4'b0111) || (op == 4'b1010) || (op >= 4'b1100);
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] y);
    if (op == 4'b1000 || op == 4'b1001 || op == 4'b1011) return int'(y[4:0]) + 1;
    return 1;
  endfunction

  // Transaction-level model: remembers the pending answer and counts edges to completion.
  logic        m_busy = 1'b0, m_done = 1'b0, m_illegal = 1'b0, m_pend_ill = 1'b0;
  logic [31:0] m_result = 32'd0, m_pend = 32'd0;
  int          m_left = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 1'b0; m_done = 1'b0; m_illegal = 1'b0; m_result = 32'd0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_result = m_pend; m_illegal = m_pend_ill;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_left = ref_lat(alu_op, b);
        m_pend = ref_alu(alu_op, a, b);
        m_pend_ill = is_undef(alu_op);
        m_illegal = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("cyc_done", {31'd0, done}, {31'd0, m_done});
      chk("cyc_result", result, m_result);
      chk("cyc_zero", {31'd0, zero}, {31'd0, m_result == 32'd0});
      chk("cyc_illegal", {31'd0, illegal}, {31'd0, m_illegal});
    end
  end

  task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp_r, input int exp_l, input logic exp_ill, input bit disturb);
    int lat;
    @(negedge clk);
    start = 1'b1; alu_op = op; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_accept_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (disturb && lat == 1) begin
        start = 1'b1; alu_op = 4'b0000; a = 32'd1; b = 32'd1;
      end
      if (disturb && lat == 3) start = 1'b0;
    end
    chk({nm, "_latency"}, lat, exp_l);
    chk({nm, "_result"}, result, exp_r);
    chk({nm, "_zero"}, {31'd0, zero}, {31'd0, exp_r == 32'd0});
    chk({nm, "_illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
    chk({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    chk_en = 1'b1;

    do_op("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 1'b0, 1'b0);
    do_op("sub_eq",  4'b0001, 32'd5, 32'd5, 32'h0000_0000, 1, 1'b0, 1'b0);
    do_op("slt",     4'b0010, 32'hFFFF_FFFF, 32'd1, 32'h0000_0001, 1, 1'b0, 1'b0);
    do_op("sltu",    4'b0011, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1, 1'b0, 1'b0);
    do_op("and",     4'b0100, 32'hF0F0_FF00, 32'h3C3C_0FF0, 32'h3030_0F00, 1, 1'b0, 1'b0);
    do_op("or",      4'b0101, 32'hF0F0_0000, 32'h0F00_000F, 32'hFFF0_000F, 1, 1'b0, 1'b0);
    do_op("xor",     4'b0110, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1, 1'b0, 1'b0);
    do_op("sub_wrap", 4'b0001, 32'd0, 32'd1, 32'hFFFF_FFFF, 1, 1'b0, 1'b0);
    do_op("sra31",   4'b1011, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32, 1'b0, 1'b0);
    do_op("sll0",    4'b1000, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 1'b0, 1'b0);
    do_op("sll_b5",  4'b1000, 32'h1234_5678, 32'h0000_0021, 32'h2468_ACF0, 2, 1'b0, 1'b0);
    do_op("srl_dist", 4'b1001, 32'hF000_0000, 32'd4, 32'h0F00_0000, 5, 1'b0, 1'b1);
    do_op("undef7",  4'b0111, 32'h1234_5678, 32'd9, 32'h0000_0000, 1, 1'b1, 1'b0);
    do_op("add_clr", 4'b0000, 32'd2, 32'd3, 32'h0000_0005, 1, 1'b0, 1'b0);

    @(negedge clk);
    start = 1'b1; alu_op = 4'b1000; a = 32'd3; b = 32'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    chk("async_result", result, 32'd0);
    chk("async_zero", {31'd0, zero}, 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_no_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    rstn = 1'b1;
    do_op("post_rst", 4'b0000, 32'h0000_1000, 32'h0000_0234, 32'h0000_1234, 1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
